// File: rtl/ulaplus_palette_mc.sv
// ulaplus_palette_mc: multi-channel ULAplus palette. One synchronous palette RAM
// is time-shared round-robin between NCH video read channels and one CPU slot.
// The CPU slot either commits a posted palette write or refreshes the readback
// shadow register.
//
// Ports:
//   clk28, rst_n     28 MHz clock, asynchronous active-low reset
//   en               ULAplus enable; 0 hides both ports and clears mode bits
//   bus_ioreq/a/d/rd/wr  CPU I/O bus (ports BF3B address, FF3B data)
//   d_out            FF3B read data (combinational from registers)
//   d_out_active     d_out is driving the CPU data bus (registered)
//   active/grayscale mode register bits 0/1
//   read_addr        packed per-channel palette indices, ADDR_W bits each
//   read_data        packed per-channel palette data, 8 bits each
module ulaplus_palette_mc #(
  parameter int unsigned NCH    = 2,
  parameter int unsigned ADDR_W = 6
) (
  input  logic                  clk28,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  bus_ioreq,
  input  logic [15:0]           bus_a,
  input  logic [7:0]            bus_d,
  input  logic                  bus_rd,
  input  logic                  bus_wr,
  output logic [7:0]            d_out,
  output logic                  d_out_active,
  output logic                  active,
  output logic                  grayscale,
  input  logic [NCH*ADDR_W-1:0] read_addr,
  output logic [NCH*8-1:0]      read_data
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned SLOT_W = $clog2(NCH + 1);

  logic [SLOT_W-1:0] slot;
  logic [SLOT_W-1:0] prev_slot;
  logic              prev_write;
  logic [7:0]        addr_reg;
  logic              ff_wr_q;
  logic [ADDR_W-1:0] wbuf_addr;
  logic [7:0]        wbuf_data;
  logic              wbuf_pend;
  logic [7:0]        shadow;
  logic [7:0]        q;
  logic [7:0]        mem [DEPTH];

  logic              cs_bf_c;
  logic              cs_ff_c;
  logic              ff_wr_c;
  logic              idx_ok_c;
  logic              mode_sel_c;
  logic              post_c;
  logic              cpu_slot_c;
  logic              commit_c;
  logic [ADDR_W-1:0] ram_addr_c;

  // Port decode and write qualification.
  always_comb begin
    cs_bf_c    = en && bus_ioreq && (bus_a == 16'hBF3B);
    cs_ff_c    = en && bus_ioreq && (bus_a == 16'hFF3B);
    ff_wr_c    = cs_ff_c && bus_wr;
    idx_ok_c   = (addr_reg[7:6] == 2'b00) && ({1'b0, addr_reg[5:0]} < 7'(DEPTH));
    mode_sel_c = (addr_reg == 8'h40);
    // Only the first cycle of a held write strobe posts.
    post_c     = ff_wr_c && !ff_wr_q && idx_ok_c;
    cpu_slot_c = (slot == SLOT_W'(NCH));
    commit_c   = cpu_slot_c && wbuf_pend;
  end

  // RAM address mux: channel slots, then CPU slot (commit or shadow refresh).
  always_comb begin
    ram_addr_c = addr_reg[ADDR_W-1:0];
    if (commit_c) begin
      ram_addr_c = wbuf_addr;
    end
    for (int unsigned k = 0; k < NCH; k++) begin
      if (slot == SLOT_W'(k)) begin
        ram_addr_c = read_addr[k*ADDR_W +: ADDR_W];
      end
    end
  end

  // Single-port palette RAM, registered output, old data on read-during-write.
  always_ff @(posedge clk28) begin
    if (commit_c) begin
      mem[ram_addr_c] <= wbuf_data;
    end
    q <= mem[ram_addr_c];
  end

  // Slot sequencing, CPU port registers, write buffer and pipeline capture.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      slot         <= '0;
      prev_slot    <= SLOT_W'(NCH);
      prev_write   <= 1'b0;
      addr_reg     <= 8'h00;
      ff_wr_q      <= 1'b0;
      wbuf_addr    <= '0;
      wbuf_data    <= 8'h00;
      wbuf_pend    <= 1'b0;
      active       <= 1'b0;
      grayscale    <= 1'b0;
      d_out_active <= 1'b0;
      shadow       <= 8'h00;
      read_data    <= '0;
    end else begin
      slot       <= cpu_slot_c ? '0 : slot + SLOT_W'(1);
      prev_slot  <= slot;
      prev_write <= commit_c;
      ff_wr_q    <= ff_wr_c;

      if (cs_bf_c && bus_wr) begin
        addr_reg <= bus_d;
      end

      // A post in the commit slot wins: old buffer commits, new one stays pending.
      if (post_c) begin
        wbuf_addr <= addr_reg[ADDR_W-1:0];
        wbuf_data <= bus_d;
        wbuf_pend <= 1'b1;
      end else if (commit_c) begin
        wbuf_pend <= 1'b0;
      end

      if (!en) begin
        active    <= 1'b0;
        grayscale <= 1'b0;
      end else if (ff_wr_c && mode_sel_c) begin
        active    <= bus_d[0];
        grayscale <= bus_d[1];
      end

      d_out_active <= cs_ff_c && bus_rd;

      // q belongs to the slot of the previous edge.
      for (int unsigned k = 0; k < NCH; k++) begin
        if (prev_slot == SLOT_W'(k)) begin
          read_data[k*8 +: 8] <= q;
        end
      end
      if ((prev_slot == SLOT_W'(NCH)) && !prev_write) begin
        shadow <= q;
      end
    end
  end

  // FF3B readback mux.
  always_comb begin
    d_out = 8'hFF;
    if (idx_ok_c) begin
      d_out = shadow;
    end else if (mode_sel_c) begin
      d_out = {6'b0, grayscale, active};
    end
  end

endmodule

// File: tb/tb_ulaplus_palette_mc.sv
// Testbench for ulaplus_palette_mc (NCH = 4, ADDR_W = 4).
module tb_ulaplus_palette_mc;

  localparam int NCH    = 4;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int PER    = NCH + 1;

  logic                  clk28;
  logic                  rst_n;
  logic                  en;
  logic                  bus_ioreq;
  logic [15:0]           bus_a;
  logic [7:0]            bus_d;
  logic                  bus_rd;
  logic                  bus_wr;
  logic [7:0]            d_out;
  logic                  d_out_active;
  logic                  active;
  logic                  grayscale;
  logic [NCH*ADDR_W-1:0] read_addr;
  logic [NCH*8-1:0]      read_data;

  ulaplus_palette_mc #(.NCH(NCH), .ADDR_W(ADDR_W)) dut (
    .clk28        (clk28),
    .rst_n        (rst_n),
    .en           (en),
    .bus_ioreq    (bus_ioreq),
    .bus_a        (bus_a),
    .bus_d        (bus_d),
    .bus_rd       (bus_rd),
    .bus_wr       (bus_wr),
    .d_out        (d_out),
    .d_out_active (d_out_active),
    .active       (active),
    .grayscale    (grayscale),
    .read_addr    (read_addr),
    .read_data    (read_data)
  );

  initial clk28 = 1'b0;
  always #5 clk28 = ~clk28;

  // Reference model state.
  logic [7:0] ref_mem [DEPTH];
  logic       ref_active;
  logic       ref_gray;
  logic [7:0] ref_addr;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [7:0] bf;
    logic [7:0] data;
    logic [7:0] exp_rd;
  } vec_t;
  vec_t vecs [9];

  int         ah [40][NCH];
  int         last_chg [NCH];
  int         n_chg [NCH];
  logic [7:0] prev [NCH];

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] ch_data(input int k);
    return read_data[k*8 +: 8];
  endfunction

  function automatic int ch_idx(input int k);
    return int'(read_addr[k*ADDR_W +: ADDR_W]);
  endfunction

  task automatic set_ch(input int k, input int idx);
    read_addr[k*ADDR_W +: ADDR_W] = ADDR_W'(idx);
  endtask

  task automatic tick();
    @(posedge clk28);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic io_write(input logic [15:0] a, input logic [7:0] d);
    tick();
    bus_ioreq = 1'b1; bus_a = a; bus_d = d; bus_wr = 1'b1;
    tick();
    bus_ioreq = 1'b0; bus_a = 16'h0000; bus_wr = 1'b0;
  endtask

  // Model of the CPU-visible register/palette effect of a BF3B+FF3B pair.
  task automatic model_write(input logic [7:0] bf, input logic [7:0] data);
    if (en) begin
      ref_addr = bf;
      if (bf[7:6] == 2'b00 && int'(bf[5:0]) < DEPTH) ref_mem[bf[3:0]] = data;
      if (bf == 8'h40) begin
        ref_active = data[0];
        ref_gray   = data[1];
      end
    end
  endtask

  task automatic cpu_write(input logic [7:0] bf, input logic [7:0] data);
    io_write(16'hBF3B, bf);
    io_write(16'hFF3B, data);
    model_write(bf, data);
    cycles(PER + 1);
  endtask

  function automatic logic [7:0] exp_ff();
    if (ref_addr[7:6] == 2'b00 && int'(ref_addr[5:0]) < DEPTH) return ref_mem[ref_addr[3:0]];
    if (ref_addr == 8'h40) return {6'b0, ref_gray, ref_active};
    return 8'hFF;
  endfunction

  task automatic ff_read(input string name, input int hold, output logic [7:0] got);
    bus_ioreq = 1'b1; bus_a = 16'hFF3B; bus_rd = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({name, "_act"}, {7'b0, d_out_active}, 8'h01);
    end
    got = d_out;
    chk({name, "_dout"}, d_out, exp_ff());
    bus_ioreq = 1'b0; bus_a = 16'h0000; bus_rd = 1'b0;
    tick();
    chk({name, "_act_off"}, {7'b0, d_out_active}, 8'h00);
  endtask

  task automatic check_channels(input string name);
    for (int k = 0; k < NCH; k++)
      chk($sformatf("%s_ch%0d", name, k), ch_data(k), ref_mem[ch_idx(k)]);
  endtask

  task automatic check_mode(input string name);
    chk({name, "_active"}, {7'b0, active}, {7'b0, ref_active});
    chk({name, "_gray"}, {7'b0, grayscale}, {7'b0, ref_gray});
  endtask

  initial begin
    logic [7:0] got;
    logic [7:0] old;
    int         found;

    vecs[0] = '{8'h05, 8'h5B, 8'h5B};
    vecs[1] = '{8'h03, 8'h3C, 8'h3C};
    vecs[2] = '{8'h0F, 8'h11, 8'h11};
    vecs[3] = '{8'h13, 8'h55, 8'hFF};
    vecs[4] = '{8'h40, 8'h03, 8'h03};
    vecs[5] = '{8'h80, 8'h12, 8'hFF};
    vecs[6] = '{8'hC5, 8'h77, 8'hFF};
    vecs[7] = '{8'h40, 8'h01, 8'h01};
    vecs[8] = '{8'h00, 8'hE4, 8'hE4};

    n_checks = 0; n_fail = 0;
    ref_active = 1'b0; ref_gray = 1'b0; ref_addr = 8'h00;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    rst_n = 1'b0; en = 1'b1;
    bus_ioreq = 1'b0; bus_a = 16'h0000; bus_d = 8'h00; bus_rd = 1'b0; bus_wr = 1'b0;
    read_addr = '0;

    // Reset values, during and right after reset.
    cycles(3);
    check_mode("rst");
    chk("rst_dact", {7'b0, d_out_active}, 8'h00);
    for (int k = 0; k < NCH; k++) chk($sformatf("rst_rd%0d", k), ch_data(k), 8'h00);
    @(negedge clk28);
    rst_n = 1'b1;
    #1;
    check_mode("rel");
    for (int k = 0; k < NCH; k++) chk($sformatf("rel_rd%0d", k), ch_data(k), 8'h00);

    // Preload every index with data whose high nibble is the index.
    for (int i = 0; i < DEPTH; i++)
      cpu_write(8'(i), {4'(i), 4'($urandom)});
    set_ch(0, 1); set_ch(1, 6); set_ch(2, 11); set_ch(3, 14);
    cycles(2 * PER);
    check_channels("preload");

    // Channel latency (2 edges from address to data) and exact period.
    for (int k = 0; k < NCH; k++) begin
      last_chg[k] = -1; n_chg[k] = 0; prev[k] = ch_data(k);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      for (int k = 0; k < NCH; k++) begin
        if (ch_data(k) !== prev[k]) begin
          if (i >= 2) chk($sformatf("lat_ch%0d", k), ch_data(k), ref_mem[ah[i-2][k]]);
          if (last_chg[k] >= 0) chk($sformatf("period_ch%0d", k), 8'(i - last_chg[k]), 8'(PER));
          last_chg[k] = i; n_chg[k]++; prev[k] = ch_data(k);
        end
      end
      for (int k = 0; k < NCH; k++) begin
        ah[i][k] = (k * 4 + i + 8) % DEPTH;
        set_ch(k, ah[i][k]);
      end
    end
    for (int k = 0; k < NCH; k++) begin
      chk($sformatf("nchg_ch%0d", k), {7'b0, n_chg[k] >= 7}, 8'h01);
      chk($sformatf("phase_ch%0d", k), 8'((((last_chg[k] - last_chg[0]) % PER) + PER) % PER), 8'(k));
    end

    // Write path: channel 1 shows the new value within 2*(NCH+1) cycles.
    set_ch(0, 2); set_ch(1, 5); set_ch(2, 9); set_ch(3, 12);
    cycles(2 * PER);
    io_write(16'hBF3B, 8'h05);
    model_write(8'h05, ref_mem[5]);
    io_write(16'hFF3B, 8'hA7);
    ref_mem[5] = 8'hA7;
    found = 0;
    for (int i = 0; i < 2 * PER - 1 && found == 0; i++) begin
      if (ch_data(1) == 8'hA7) found = 1;
      else tick();
    end
    chk("wr_ch1_a7", ch_data(1), 8'hA7);
    check_channels("wr_others");

    // Readback with a long strobe.
    ff_read("rb_hold", 20, got);
    chk("rb_a7", got, 8'hA7);
    cpu_write(8'h40, 8'h03);
    check_mode("mode03");
    ff_read("rb_mode", 12, got);
    chk("rb_03", got, 8'h03);

    // Vector table.
    for (int i = 0; i < 9; i++) begin
      cpu_write(vecs[i].bf, vecs[i].data);
      set_ch(0, 3); set_ch(1, 5); set_ch(2, 15); set_ch(3, 0);
      cycles(2 * PER);
      check_channels($sformatf("vec%0d", i));
      check_mode($sformatf("vec%0d", i));
      ff_read($sformatf("vec%0d", i), 12, got);
      chk($sformatf("vec%0d_tbl", i), got, vecs[i].exp_rd);
    end

    // Held write strobe posts once, with the first cycle's data.
    io_write(16'hBF3B, 8'h07);
    model_write(8'h07, ref_mem[7]);
    tick();
    bus_ioreq = 1'b1; bus_a = 16'hFF3B; bus_d = 8'h5A; bus_wr = 1'b1;
    tick();
    bus_d = 8'hC3;
    cycles(10);
    bus_ioreq = 1'b0; bus_a = 16'h0000; bus_wr = 1'b0;
    ref_mem[7] = 8'h5A;
    set_ch(0, 7);
    cycles(2 * PER + 1);
    check_channels("held_wr");
    ff_read("held_wr", 12, got);

    // Disable: mode cleared next cycle, ports ignored, RAM kept.
    cpu_write(8'h40, 8'h03);
    check_mode("pre_dis");
    bus_ioreq = 1'b1; bus_a = 16'hFF3B; bus_rd = 1'b1;
    tick();
    chk("dis_dact_on", {7'b0, d_out_active}, 8'h01);
    en = 1'b0;
    tick();
    ref_active = 1'b0; ref_gray = 1'b0;
    check_mode("dis");
    chk("dis_dact_off", {7'b0, d_out_active}, 8'h00);
    bus_ioreq = 1'b0; bus_a = 16'h0000; bus_rd = 1'b0;
    old = ref_mem[2];
    cpu_write(8'h02, ~old);
    cpu_write(8'h40, 8'h03);
    check_mode("dis_wr");
    en = 1'b1;
    set_ch(2, 2);
    cycles(2 * PER);
    check_mode("reen");
    chk("reen_ram", ch_data(2), old);
    ff_read("reen", 12, got);

    // Randomized writes and channel reads against the model.
    for (int it = 0; it < 25; it++) begin
      logic [7:0] bf;
      bf = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 5) == 0) bf = 8'h40;
      cpu_write(bf, 8'($urandom));
      for (int k = 0; k < NCH; k++) set_ch(k, $urandom_range(0, DEPTH - 1));
      cycles(2 * PER);
      check_channels($sformatf("rnd%0d", it));
      check_mode($sformatf("rnd%0d", it));
      ff_read($sformatf("rnd%0d", it), 12, got);
    end

    // Mid-operation reset loses a pending write and clears mode.
    cpu_write(8'h40, 8'h03);
    set_ch(0, 9);
    old = ref_mem[9];
    io_write(16'hBF3B, 8'h09);
    tick();
    bus_ioreq = 1'b1; bus_a = 16'hFF3B; bus_d = ~old; bus_wr = 1'b1;
    tick();
    rst_n = 1'b0;
    bus_ioreq = 1'b0; bus_a = 16'h0000; bus_wr = 1'b0;
    ref_active = 1'b0; ref_gray = 1'b0; ref_addr = 8'h00;
    #1;
    check_mode("mid_rst");
    cycles(2);
    rst_n = 1'b1;
    cycles(3 * PER);
    chk("mid_rst_lost", ch_data(0), old);
    check_mode("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ulaplus_palette_mc.md
# ulaplus_palette_mc

Parametrised multi-channel ULAplus palette unit for the video path, sitting between the CPU I/O bus and the pixel pipeline. It holds the palette in one synchronous RAM and serves NCH independent video read channels plus one CPU slot in a fixed round-robin. Unlike the fixed two-channel palette, it supports CPU palette readback, the ULAplus grayscale mode bit and configurable palette depth.

## Interface
- NCH, 2: video read channels, 1..4
- ADDR_W, 6: palette index width, 4..6; DEPTH = 2**ADDR_W entries of 8 bits
- clk28  in  1  system clock (28 MHz)
- rst_n  in  1  asynchronous active-low reset
- en  in  1  ULAplus enable; 0 hides ports and clears mode bits
- bus  cpu_bus  —  CPU bus interface (ioreq, a[15:0], d[7:0], rd, wr)
- d_out  out  8  read data for port FF3B
- d_out_active  out  1  d_out drives the CPU data bus
- active  out  1  palette mode enabled (mode reg bit 0)
- grayscale  out  1  grayscale mode (mode reg bit 1)
- read_addr  in  NCH*ADDR_W  packed channel indices; channel k = bits [k*ADDR_W +: ADDR_W]
- read_data  out  NCH*8  packed channel palette data, same packing

## Operation
- Port BF3B (ioreq, a==16'hBF3B, en): write loads addr_reg[7:0].
- Port FF3B (ioreq, a==16'hFF3B, en):
  - group = addr_reg[7:6]
  - write with group 00 and addr_reg[5:0] < DEPTH posts a palette write: wbuf_addr <= addr_reg[ADDR_W-1:0], wbuf_data <= bus.d, wbuf_pend <= 1
  - posting happens on the first cycle of cs&&wr only (rising-edge detect), not again for the rest of the strobe
  - a new post before commit overwrites wbuf; the newer write wins
  - write with addr_reg == 8'h40: active <= d[0], grayscale <= d[1]
  - other groups or out-of-range indices: write ignored
- FF3B read data (d_out, combinational from registers):
  - group 00, index < DEPTH: shadow
  - addr_reg == 8'h40: {6'b0, grayscale, active}
  - otherwise: 8'hFF
- d_out_active: registered copy of (FF3B cs && bus.rd).
- en == 0: active and grayscale are forced to 0 every cycle, both ports are ignored, and d_out_active is 0 one cycle later. A pending wbuf still commits. RAM contents are kept.
- Slot counter slot cycles 0..NCH, then wraps to 0.
  - slot k < NCH: RAM address = read_addr channel k, read only
  - slot NCH (CPU slot), wbuf_pend == 1: RAM address = wbuf_addr, we = 1, wbuf_pend <= 0
  - slot NCH, wbuf_pend == 0: RAM address = addr_reg index (shadow refresh)
- RAM: single port, synchronous; q is registered and returns old data on read-during-write.
- Pipeline capture, on the edge after the slot edge (using a registered prev_slot):
  - prev_slot k < NCH: read_data[k] <= q
  - prev_slot NCH, and that slot was a refresh read: shadow <= q
  - prev_slot NCH, and that slot was a write: shadow is left unchanged

## Timing
- Reset values:
  - slot = 0, prev_slot = NCH
  - addr_reg, wbuf_pend, active, grayscale = 0
  - read_data all 0, shadow = 0, d_out_active = 0
  - RAM is not initialised
- Channel latency:
  - read_addr[k] is sampled at the edge where slot == k
  - read_data[k] updates exactly one edge later
  - each channel refreshes every NCH+1 cycles
- Write commit: at most NCH+1 cycles after the post. It is visible to channel reads in the first channel slot after the commit edge.
- Shadow staleness after an addr_reg change or commit: at most 2*(NCH+1)+1 cycles, which is well inside a Z80 I/O cycle at 28 MHz.
- Simultaneous events: a write strobe and a CPU slot on the same edge give post first, commit in the following CPU slot.
- Mid-operation reset: clears all state asynchronously, and a pending write is lost.

## Test plan
- Reset: during and after rst_n low, active = 0, grayscale = 0, read_data = 0, d_out_active = 0, slot = 0.
- Write path:
  - stimulus: BF3B <= 8'h05, FF3B <= 8'hA7, then channel 1 addr = 5
  - required: channel 1 shows 8'hA7 within 2*(NCH+1) cycles of the FF3B strobe; all other channels unaffected
- Readback:
  - stimulus: after the above, hold FF3B rd for 20 cycles
  - required: d_out_active = 1 from the cycle after rd; d_out = 8'hA7
  - stimulus: BF3B <= 8'h40, FF3B <= 8'h03
  - required: active = 1, grayscale = 1, FF3B read = 8'h03
- Channels: NCH = 4, each channel on a distinct preloaded index -> each read_data[k] correct, with period exactly 5 cycles.
- Boundaries:
  - stimulus: ADDR_W = 4, BF3B <= 8'h13, FF3B write
  - required: no RAM change; FF3B read = 8'hFF
  - stimulus: addr_reg = 8'h80, FF3B read
  - required: FF3B read = 8'hFF
- Disable: with active = 1, drop en -> active and grayscale = 0 next cycle; port writes ignored; RAM retains data after en returns.
